// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    // HI/LO operation encoding as decoded alongside the ALU control
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MF    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step_r0.sv
// One radix-2 iteration of the shift-add multiply / restoring divide.
// acc_hi:acc_lo is the 2*WIDTH working register. Multiply keeps the
// partial product in acc_hi and the remaining multiplier bits in acc_lo.
// Divide keeps the partial remainder in acc_hi and shifts dividend bits
// out of acc_lo while quotient bits shift in from the bottom.
module muldiv_step_r0 #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   mul_val;
    logic [WIDTH+1:0] sum;

    // Shared WIDTH+1-bit adder; top carry on subtract means "no borrow"
    always_comb begin
        add_a      = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
        add_b      = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
        sum        = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};
        mul_val    = acc_lo[0] ? sum[WIDTH:0] : add_a;
        acc_hi_nxt = mul_val[WIDTH:1];
        acc_lo_nxt = {mul_val[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (sum[WIDTH+1]) begin
                acc_hi_nxt = sum[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt = add_a[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_controller_r0.sv
// HI/LO owner for the EX stage: sequences multi-cycle MULT/DIV, handles
// MTHI/MTLO writes and stalls any HI/LO instruction while busy.
// Handshake: an op is taken only when op_valid=1, busy=0 and flush=0;
// while busy, op_valid raises stall and the pipeline re-presents the op.
module muldiv_controller_r0
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_res, neg_rem, div_zero;
    logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt;

    logic             start, op_signed, op_div;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;

    muldiv_step_r0 #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .acc_hi     (acc_hi),
        .acc_lo     (acc_lo),
        .opnd       (opnd),
        .acc_hi_nxt (acc_hi_nxt),
        .acc_lo_nxt (acc_lo_nxt)
    );

    // Operand conditioning and final sign correction
    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        start     = (state == S_IDLE) && op_valid && !flush &&
                    (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
        rs_mag    = (op_signed && rs_val[WIDTH-1]) ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = (op_signed && rt_val[WIDTH-1]) ? (~rt_val + 1'b1) : rt_val;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_res ? (~prod + 1'b1) : prod;
        q_fix     = neg_res ? (~acc_lo + 1'b1) : acc_lo;
        r_fix     = neg_rem ? (~acc_hi + 1'b1) : acc_hi;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; flush aborts from any busy state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: begin
                if (flush)                        state_nxt = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))   state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy      = (state != S_IDLE);
        stall     = op_valid && busy && !flush;
        state_dbg = state;
    end

    // Datapath, counter and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        is_div   <= op_div;
                        div_zero <= op_div && (rt_val == '0);
                        neg_res  <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem  <= op_signed && op_div && rs_val[WIDTH-1];
                        if (op_div) begin
                            acc_lo <= rs_mag;
                            // A zero divisor is never needed, so the raw
                            // dividend parks here for the HI result.
                            opnd   <= (rt_val == '0) ? rs_val : rt_mag;
                        end else begin
                            acc_lo <= rt_mag;
                            opnd   <= rs_mag;
                        end
                    end else if (op_valid && !flush) begin
                        case (op)
                            OP_MTHI:       hi_out <= rs_val;
                            OP_MTLO:       lo_out <= rs_val;
                            OP_NOP, OP_MF: ;
                            default:       ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc_hi <= acc_hi_nxt;
                        acc_lo <= acc_lo_nxt;
                        cnt    <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_out <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_out <= opnd;
                            lo_out <= '1;
                        end else begin
                            hi_out <= r_fix;
                            lo_out <= q_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller_r0.sv
// Directed bench for the HI/LO multiply/divide sequencer.
module tb_muldiv_controller_r0;

    localparam int W = 32;

    logic         clk, reset_n, op_valid, flush;
    logic [2:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, stall, done;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_controller_r0 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
    endtask

    // Called with an arithmetic op already presented; the next edge accepts it.
    task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
        int nb       = 0;
        int bad_done = 0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        op = 3'd0;
        @(negedge clk);
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (done !== 1'b0) bad_done++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd33);
        chk({tag, "_early_done"}, 32'(bad_done), 32'd0);
        chk({tag, "_hi"}, hi_out, eh);
        chk({tag, "_lo"}, lo_out, el);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    // Directed sequence
    initial begin
        int nb;
        reset_n  = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        flush    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // MTHI in IDLE: one edge, never busy
        @(posedge clk); #1 issue(3'd5, 32'h12345678, 32'h0);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        chk("mthi_hi", hi_out, 32'h12345678);
        chk("mthi_lo", lo_out, 32'h0);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_done", 32'(done), 32'd0);

        // MULTU max x max, then MULT accepted in the first idle cycle
        @(posedge clk); #1 issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("multu_max", 32'hFFFFFFFE, 32'h00000001);
        issue(3'd1, 32'hFFFFFFFD, 32'd7);
        finish_op("mult_b2b", 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);

        // Divides, including zero divisor and the overflow case
        @(posedge clk); #1 issue(3'd3, 32'hFFFFFFF9, 32'd2);
        finish_op("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        @(posedge clk); #1 issue(3'd4, 32'd7, 32'd0);
        finish_op("divu_by0", 32'd7, 32'hFFFFFFFF);
        @(posedge clk); #1 issue(3'd3, 32'hFFFFFFF9, 32'd0);
        finish_op("div_by0", 32'hFFFFFFF9, 32'hFFFFFFFF);
        @(posedge clk); #1 issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_ovf", 32'h0, 32'h80000000);
        @(posedge clk); #1 issue(3'd4, 32'd100, 32'd7);
        finish_op("divu_100_7", 32'd2, 32'd14);
        @(posedge clk); #1 issue(3'd3, 32'd7, 32'hFFFFFFFE);
        finish_op("div_7_neg2", 32'd1, 32'hFFFFFFFD);

        // MULT 6x7 with MF held from cycle 5: stall until result visible
        @(posedge clk); #1 issue(3'd1, 32'd6, 32'd7);
        @(posedge clk); #1 op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 issue(3'd7, 32'h0, 32'h0);
        @(negedge clk);
        chk("mf_stall", 32'(stall), 32'd1);
        chk("mf_state_calc", 32'(state_dbg), 32'd1);
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            if (stall !== 1'b1) nb = 1000;
            @(negedge clk);
        end
        chk("mf_stall_held", 32'(nb < 200), 32'd1);
        chk("mf_stall_drop", 32'(stall), 32'd0);
        chk("mf_lo", lo_out, 32'd42);
        chk("mf_hi", hi_out, 32'd0);
        @(posedge clk); #1 op_valid = 1'b0;

        // MTLO presented while busy is stalled and not written
        @(posedge clk); #1 issue(3'd2, 32'd3, 32'd5);
        @(posedge clk); #1 issue(3'd6, 32'hDEAD, 32'h0);
        #1 chk("mtlo_stall", 32'(stall), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mtlo_lo_hold", lo_out, 32'd42);
        @(posedge clk); #1 op_valid = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        chk("mtlo_wait", 32'(nb < 200), 32'd1);
        chk("mtlo_multu_lo", lo_out, 32'd15);
        chk("mtlo_multu_hi", hi_out, 32'd0);

        // Flush mid-divide leaves HI/LO intact
        @(posedge clk); #1 issue(3'd5, 32'h11, 32'h0);
        @(posedge clk); #1 issue(3'd6, 32'h22, 32'h0);
        @(posedge clk); #1 issue(3'd3, 32'd100, 32'd3);
        @(posedge clk); #1 op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi_out, 32'h11);
        chk("flush_lo", lo_out, 32'h22);
        chk("flush_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("flush_done_late", 32'(done), 32'd0);

        // Asynchronous reset mid-divide clears everything at once
        @(posedge clk); #1 issue(3'd3, 32'd100, 32'd3);
        @(posedge clk); #1 op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_hi", hi_out, 32'h0);
        chk("arst_lo", lo_out, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Normal operation after reset
        @(posedge clk); #1 issue(3'd2, 32'h00010000, 32'h00010000);
        finish_op("multu_post_rst", 32'h1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
